// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register in front of the ALU: decodes RV32I opcode/funct
// fields into an ALU select, picks and forwards operands, and holds them
// behind a single-entry valid/ready handshake with a flush for redirects.
module alu_operand_stage #(
    parameter int          XLEN      = 32,
    parameter logic [3:0]  RESET_SEL = 4'b0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            exm_wr_en,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            mwb_wr_en,
    input  logic [4:0]      mwb_rd,
    input  logic [XLEN-1:0] mwb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_sel,
    output logic [4:0]      out_rd,
    output logic            out_br_inv,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] SEL_ADD   = 4'b0000;
    localparam logic [3:0] SEL_SLT   = 4'b0010;
    localparam logic [3:0] SEL_SLTU  = 4'b0011;
    localparam logic [3:0] SEL_EQ    = 4'b1010;
    localparam logic [3:0] SEL_PASSB = 4'b1111;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    logic [3:0]      alu_sel_q, alu_sel_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic            br_inv_q, br_inv_d;
    logic            illegal_q, illegal_d;

    logic            xfer;
    logic [XLEN-1:0] src1, src2;

    // Forwarded value of one source register; x0 always reads zero, and the
    // younger EX/MEM result takes priority over MEM/WB.
    function automatic logic [XLEN-1:0] fwd(input logic [4:0]      addr,
                                            input logic [XLEN-1:0] rf_data);
        if (addr == 5'd0)                        return '0;
        else if (exm_wr_en && exm_rd == addr)    return exm_data;
        else if (mwb_wr_en && mwb_rd == addr)    return mwb_data;
        else                                     return rf_data;
    endfunction

    assign in_ready = !valid_q || out_ready;
    assign xfer     = in_valid && in_ready;
    assign src1     = fwd(rs1_addr, rs1_data);
    assign src2     = fwd(rs2_addr, rs2_data);

    // Decode the incoming instruction into ALU select and operand choices.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        alu_sel_d = RESET_SEL;
        alu_a_d   = '0;
        alu_b_d   = '0;
        out_rd_d  = rd_addr;
        br_inv_d  = 1'b0;
        illegal_d = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                alu_sel_d = {funct7_5 & (funct3 == 3'b000 || funct3 == 3'b101), funct3};
                alu_a_d   = src1;
                alu_b_d   = src2;
            end
            OPC_OP_IMM: begin
                alu_sel_d = {funct7_5 & (funct3 == 3'b101), funct3};
                alu_a_d   = src1;
                alu_b_d   = imm;
            end
            OPC_LUI: begin
                alu_sel_d = SEL_PASSB;
                alu_b_d   = imm;
            end
            OPC_AUIPC: begin
                alu_sel_d = SEL_ADD;
                alu_a_d   = pc;
                alu_b_d   = imm;
            end
            OPC_LOAD, OPC_STORE: begin
                alu_sel_d = SEL_ADD;
                alu_a_d   = src1;
                alu_b_d   = imm;
                if (opcode == OPC_STORE) out_rd_d = 5'd0;
            end
            OPC_BRANCH: begin
                alu_a_d  = src1;
                alu_b_d  = src2;
                out_rd_d = 5'd0;
                br_inv_d = funct3[0];
                unique case (funct3[2:1])
                    2'b00:   alu_sel_d = SEL_EQ;
                    2'b10:   alu_sel_d = SEL_SLT;
                    2'b11:   alu_sel_d = SEL_SLTU;
                    default: illegal_d = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                alu_sel_d = SEL_ADD;
                alu_a_d   = pc;
                alu_b_d   = XLEN'(4);
            end
            default: begin
                out_rd_d  = 5'd0;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Next-state of the valid flag: flush beats a transfer, a consumed entry
    // without a replacement empties the stage.
    always_comb begin
        valid_d = valid_q;
        if (flush)          valid_d = 1'b0;
        else if (xfer)      valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
    end

    // Pipeline registers: reset clears everything, a transfer loads the data.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            valid_q   <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= RESET_SEL;
            out_rd_q  <= 5'd0;
            br_inv_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (xfer && !flush) begin
                alu_a_q   <= alu_a_d;
                alu_b_q   <= alu_b_d;
                alu_sel_q <= alu_sel_d;
                out_rd_q  <= out_rd_d;
                br_inv_q  <= br_inv_d;
                illegal_q <= illegal_d;
            end
        end
    end

    assign out_valid   = valid_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign out_rd      = out_rd_q;
    assign out_br_inv  = br_inv_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: decode, forwarding, handshake stall,
// flush and reset, each checked against hand-computed values.
module tb_alu_operand_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, funct7_5;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0] rs1_data, rs2_data, imm, pc;
    logic            exm_wr_en, mwb_wr_en;
    logic [4:0]      exm_rd, mwb_rd;
    logic [XLEN-1:0] exm_data, mwb_data;
    logic            flush, out_valid, out_ready;
    logic [XLEN-1:0] alu_a, alu_b;
    logic [3:0]      alu_sel;
    logic [4:0]      out_rd;
    logic            out_br_inv, out_illegal;

    int n_checks = 0;
    int n_pass   = 0;

    alu_operand_stage #(.XLEN(XLEN), .RESET_SEL(4'b0000)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .out_rd(out_rd),
        .out_br_inv(out_br_inv), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2);
        opcode = op;  funct3 = f3;  funct7_5 = f7;
        rs1_addr = r1; rs2_addr = r2; rd_addr = rd;
        rs1_data = d1; rs2_data = d2;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        instr(7'b0110011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        imm = '0; pc = '0;
        exm_wr_en = 1'b0; exm_rd = '0; exm_data = '0;
        mwb_wr_en = 1'b0; mwb_rd = '0; mwb_data = '0;
        tick(); tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sel", 32'(alu_sel), 32'h0);
        check("rst_a", alu_a, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // OP add x3 = x1 + x2
        in_valid = 1'b1;
        instr(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        tick();
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_a", alu_a, 32'd5);
        check("add_b", alu_b, 32'd7);
        check("add_sel", 32'(alu_sel), 32'h0);
        check("add_rd", 32'(out_rd), 32'd3);

        // OP sra, OP-IMM addi with bit30 set, OP-IMM srai
        instr(7'b0110011, 3'b101, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        tick();
        check("sra_sel", 32'(alu_sel), 32'hD);
        instr(7'b0010011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        imm = 32'h10;
        tick();
        check("addi_sel", 32'(alu_sel), 32'h0);
        check("addi_b", alu_b, 32'h10);
        instr(7'b0010011, 3'b101, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        tick();
        check("srai_sel", 32'(alu_sel), 32'hD);

        // Forwarding: both stages hit x4, EX/MEM wins; rs2 misses
        instr(7'b0110011, 3'b000, 1'b0, 5'd4, 5'd5, 5'd7, 32'd0, 32'h55);
        exm_wr_en = 1'b1; exm_rd = 5'd4; exm_data = 32'hAAAA0000;
        mwb_wr_en = 1'b1; mwb_rd = 5'd4; mwb_data = 32'h11111111;
        tick();
        check("fwd_exm", alu_a, 32'hAAAA0000);
        check("fwd_miss_b", alu_b, 32'h55);
        exm_wr_en = 1'b0;
        tick();
        check("fwd_mwb", alu_a, 32'h11111111);
        rs1_addr = 5'd0; rs1_data = 32'hDEAD;
        exm_wr_en = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0;
        tick();
        check("fwd_x0", alu_a, 32'd0);
        exm_wr_en = 1'b0; mwb_wr_en = 1'b0;

        // Stall: held entry (add, rd=7) must stay while next xor waits
        out_ready = 1'b0;
        instr(7'b0110011, 3'b100, 1'b0, 5'd1, 5'd2, 5'd6, 32'h0F, 32'hF0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_rd", 32'(out_rd), 32'd7);
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_sel", 32'(alu_sel), 32'h4);
        check("b2b_a", alu_a, 32'h0F);
        check("b2b_rd", 32'(out_rd), 32'd6);

        // BRANCH bgeu
        instr(7'b1100011, 3'b111, 1'b0, 5'd1, 5'd2, 5'd9, 32'd3, 32'd8);
        tick();
        check("bgeu_sel", 32'(alu_sel), 32'h3);
        check("bgeu_inv", 32'(out_br_inv), 32'd1);
        check("bgeu_rd", 32'(out_rd), 32'd0);
        check("bgeu_b", alu_b, 32'd8);
        instr(7'b1100011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd9, 32'd3, 32'd8);
        tick();
        check("br01x_illegal", 32'(out_illegal), 32'd1);

        // JAL link value
        instr(7'b1101111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd1, 32'd3, 32'd8);
        pc = 32'h100;
        tick();
        check("jal_a", alu_a, 32'h100);
        check("jal_b", alu_b, 32'd4);
        check("jal_sel", 32'(alu_sel), 32'h0);
        check("jal_illegal", 32'(out_illegal), 32'd0);

        // STORE clears destination
        instr(7'b0100011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd12, 32'h40, 32'd8);
        imm = 32'h8;
        tick();
        check("store_rd", 32'(out_rd), 32'd0);
        check("store_b", alu_b, 32'h8);

        // Unsupported opcode (FENCE)
        instr(7'b0001111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 32'h40, 32'd8);
        tick();
        check("fence_illegal", 32'(out_illegal), 32'd1);
        check("fence_rd", 32'(out_rd), 32'd0);
        check("fence_a", alu_a, 32'd0);

        // Drain without a new instruction
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // LUI then flush with a pending incoming instruction
        in_valid = 1'b1;
        instr(7'b0110111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd8, 32'h40, 32'd8);
        imm = 32'h12345000;
        tick();
        check("lui_sel", 32'(alu_sel), 32'hF);
        check("lui_b", alu_b, 32'h12345000);
        check("lui_a", alu_a, 32'd0);
        flush = 1'b1;
        tick();
        check("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;

        // Reset coinciding with a transfer of AUIPC
        instr(7'b0010111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd10, 32'h40, 32'd8);
        pc = 32'h200; imm = 32'h1000;
        tick();
        check("auipc_a", alu_a, 32'h200);
        rst = 1'b1;
        tick();
        check("rst_xfer_valid", 32'(out_valid), 32'd0);
        check("rst_xfer_a", alu_a, 32'd0);
        check("rst_xfer_b", alu_b, 32'd0);
        check("rst_xfer_rd", 32'(out_rd), 32'd0);
        rst = 1'b0;
        tick();
        check("auipc_valid", 32'(out_valid), 32'd1);
        check("auipc_b", alu_b, 32'h1000);
        check("auipc_sel", 32'(alu_sel), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
